pair_fifo_reader: RTL and testbench

PAIR_FIFO_READER -- requirements
Module: pair_fifo_reader

---
 rtl/pair_fifo_reader.sv | 172 +++++++++++++++++
 tb/tb_pair_fifo_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pair_fifo_reader.sv
// pair_fifo_reader: reads two FIFO pairs (A = FIFOs 1/2, B = FIFOs 3/4) in alternating
// bursts of packer_len words and offers them on a valid/ready port through a 3-entry buffer.
// Optional feature: define BURST_COUNT_EN to count completed bursts on burst_count.
module pair_fifo_reader #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [12:0]         packer_len,
    input  logic                fifo_empty1,
    input  logic                fifo_empty2,
    input  logic                fifo_empty3,
    input  logic                fifo_empty4,
    input  logic [DATA_W-1:0]   fifo_dout1,
    input  logic [DATA_W-1:0]   fifo_dout2,
    input  logic [DATA_W-1:0]   fifo_dout3,
    input  logic [DATA_W-1:0]   fifo_dout4,
    output logic                fifo_rd1,
    output logic                fifo_rd2,
    output logic                fifo_rd3,
    output logic                fifo_rd4,
    output logic [2*DATA_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_pair,
    output logic                out_first,
    output logic                out_last,
    output logic [15:0]         burst_count
);

    typedef enum logic [1:0] {StIdle, StRdA, StRdB, StDrain} state_e;

    state_e              state_q, state_d;
    logic [12:0]         len_q, len_d;
    logic [12:0]         cnt_q, cnt_d;
    logic                infl_q, infl_d;
    logic [2:0]          infl_tag_q, infl_tag_d;   // {pair, first, last} of the read in flight
    logic [1:0]          occ_q, occ_d;
    logic [1:0]          wr_ptr_q, wr_ptr_d;
    logic [1:0]          rd_ptr_q, rd_ptr_d;
    logic [2*DATA_W-1:0] data_mem_q [3];
    logic [2*DATA_W-1:0] data_mem_d [3];
    logic [2:0]          tag_mem_q [3];
    logic [2:0]          tag_mem_d [3];

    logic room, rd_a, rd_b, issue, push, pop;
    logic [2:0] head_tag;

    // Read strobes: only from registered state, empty flags and enable; never from out_ready.
    always_comb begin
        room  = ({1'b0, occ_q} + {2'b00, infl_q}) < 3'd3;
        rd_a  = (state_q == StRdA) && enable && !fifo_empty1 && !fifo_empty2 && room;
        rd_b  = (state_q == StRdB) && enable && !fifo_empty3 && !fifo_empty4 && room;
        issue = rd_a | rd_b;
        fifo_rd1 = rd_a;
        fifo_rd2 = rd_a;
        fifo_rd3 = rd_b;
        fifo_rd4 = rd_b;
    end

    // Output side: head of the buffer, forced to zero while the buffer is empty.
    always_comb begin
        out_valid = (occ_q != 2'd0);
        out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
        head_tag  = out_valid ? tag_mem_q[rd_ptr_q] : 3'b000;
        out_pair  = head_tag[2];
        out_first = head_tag[1];
        out_last  = head_tag[0];
        push      = infl_q;
        pop       = out_valid && out_ready;
    end

    // Next-state: FSM, burst word counter, in-flight tracking and buffer bookkeeping.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        infl_d     = issue;
        infl_tag_d = {(state_q == StRdB), (cnt_q == 13'd0), (cnt_q == len_q - 13'd1)};
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_mem_d = data_mem_q;
        tag_mem_d  = tag_mem_q;

        unique case (state_q)
            StIdle: begin
                if (enable && packer_len != 13'd0) begin
                    state_d = StRdA;
                    len_d   = packer_len;
                    cnt_d   = 13'd0;
                end
            end
            StRdA, StRdB: begin
                if (!enable) begin
                    state_d = StDrain;
                end else if (issue) begin
                    if (cnt_q == len_q - 13'd1) begin
                        cnt_d   = 13'd0;
                        state_d = (state_q == StRdA) ? StRdB : StRdA;
                    end else begin
                        cnt_d = cnt_q + 13'd1;
                    end
                end
            end
            StDrain: begin
                if (!infl_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The read issued last cycle has its data on the FIFO outputs now.
        if (push) begin
            data_mem_d[wr_ptr_q] = infl_tag_q[2] ? {fifo_dout4, fifo_dout3}
                                                 : {fifo_dout2, fifo_dout1};
            tag_mem_d[wr_ptr_q]  = infl_tag_q;
            wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end

    // State register; reset drops buffered words and any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= 13'd0;
            cnt_q      <= 13'd0;
            infl_q     <= 1'b0;
            infl_tag_q <= 3'b000;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                data_mem_q[i] <= '0;
                tag_mem_q[i]  <= 3'b000;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            infl_q     <= infl_d;
            infl_tag_q <= infl_tag_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_mem_q <= data_mem_d;
            tag_mem_q  <= tag_mem_d;
        end
    end

`ifdef BURST_COUNT_EN
    logic [15:0] bc_q, bc_d;

    // Count handshakes of burst-closing words; wraps naturally at 16 bits.
    always_comb begin
        bc_d = bc_q;
        if (pop && out_last) bc_d = bc_q + 16'd1;
    end

    // Burst counter register.
    always_ff @(posedge clk) begin
        if (reset) bc_q <= 16'd0;
        else       bc_q <= bc_d;
    end

    assign burst_count = bc_q;
`else
    assign burst_count = 16'd0;
`endif

endmodule

// File: tb/tb_pair_fifo_reader.sv
// Directed bench for pair_fifo_reader with behavioural models of the four source FIFOs.
module tb_pair_fifo_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [12:0] packer_len = 13'd0;
    logic        fifo_empty1 = 1'b1, fifo_empty2 = 1'b1, fifo_empty3 = 1'b1, fifo_empty4 = 1'b1;
    logic [15:0] fifo_dout1 = '0, fifo_dout2 = '0, fifo_dout3 = '0, fifo_dout4 = '0;
    logic        fifo_rd1, fifo_rd2, fifo_rd3, fifo_rd4;
    logic [31:0] out_data;
    logic        out_valid, out_pair, out_first, out_last;
    logic        out_ready = 1'b0;
    logic [15:0] burst_count;

    pair_fifo_reader #(.DATA_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .packer_len(packer_len),
        .fifo_empty1(fifo_empty1), .fifo_empty2(fifo_empty2),
        .fifo_empty3(fifo_empty3), .fifo_empty4(fifo_empty4),
        .fifo_dout1(fifo_dout1), .fifo_dout2(fifo_dout2),
        .fifo_dout3(fifo_dout3), .fifo_dout4(fifo_dout4),
        .fifo_rd1(fifo_rd1), .fifo_rd2(fifo_rd2), .fifo_rd3(fifo_rd3), .fifo_rd4(fifo_rd4),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pair(out_pair), .out_first(out_first), .out_last(out_last),
        .burst_count(burst_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source FIFO models: data appears on dout the cycle after the strobe.
    logic [15:0] q1[$], q2[$], q3[$], q4[$];
    logic [3:0]  hold = 4'b0;
    logic [3:0]  rd_s = 4'b0;
    bit          rule_err = 1'b0;

    task automatic refresh_empty();
        fifo_empty1 = (q1.size() == 0) || hold[0];
        fifo_empty2 = (q2.size() == 0) || hold[1];
        fifo_empty3 = (q3.size() == 0) || hold[2];
        fifo_empty4 = (q4.size() == 0) || hold[3];
    endtask

    function automatic logic [15:0] val(input int k, input int i);
        return 16'(k * 4096 + i);
    endfunction

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            q1.push_back(val(1, i)); q2.push_back(val(2, i));
            q3.push_back(val(3, i)); q4.push_back(val(4, i));
        end
        refresh_empty();
    endtask

    always @(posedge clk) begin
        if (rd_s[0] && q1.size() > 0) fifo_dout1 <= q1.pop_front();
        if (rd_s[1] && q2.size() > 0) fifo_dout2 <= q2.pop_front();
        if (rd_s[2] && q3.size() > 0) fifo_dout3 <= q3.pop_front();
        if (rd_s[3] && q4.size() > 0) fifo_dout4 <= q4.pop_front();
        fifo_empty1 <= (q1.size() == 0) || hold[0];
        fifo_empty2 <= (q2.size() == 0) || hold[1];
        fifo_empty3 <= (q3.size() == 0) || hold[2];
        fifo_empty4 <= (q4.size() == 0) || hold[3];
    end

    // Monitor: strobe counts, outstanding reads and accepted output words.
    logic [34:0] got_q[$];
    int          stamp_q[$];
    int          cyc = 0, rda_cnt = 0, rdb_cnt = 0, hs_cnt = 0, max_out = 0;

    always @(negedge clk) begin
        cyc++;
        rd_s = {fifo_rd4, fifo_rd3, fifo_rd2, fifo_rd1};
        if (fifo_rd1 != fifo_rd2 || fifo_rd3 != fifo_rd4) rule_err = 1'b1;
        if (fifo_rd1 && (fifo_empty1 || fifo_empty2)) rule_err = 1'b1;
        if (fifo_rd3 && (fifo_empty3 || fifo_empty4)) rule_err = 1'b1;
        if (reset) begin
            rda_cnt = 0; rdb_cnt = 0; hs_cnt = 0; max_out = 0;
            got_q.delete(); stamp_q.delete();
        end else begin
            if (rda_cnt + rdb_cnt - hs_cnt > max_out) max_out = rda_cnt + rdb_cnt - hs_cnt;
            if (fifo_rd1) rda_cnt++;
            if (fifo_rd3) rdb_cnt++;
            if (out_valid && out_ready) begin
                got_q.push_back({out_pair, out_first, out_last, out_data});
                stamp_q.push_back(cyc);
                hs_cnt++;
            end
        end
    end

    function automatic logic [34:0] exp_w(input bit pair, input int idx, input bit f,
                                          input bit l);
        int k = pair ? 3 : 1;
        return {pair, f, l, val(k + 1, idx), val(k, idx)};
    endfunction

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; out_ready = 1'b0; hold = 4'b0;
        q1.delete(); q2.delete(); q3.delete(); q4.delete();
        refresh_empty();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Wait for n accepted words within a cycle budget, optionally toggling out_ready.
    task automatic wait_words(input string tag, input int n, input int budget, input bit tog);
        int b = 0;
        while (got_q.size() < n && b < budget) begin
            @(posedge clk); #1;
            if (tog) out_ready = ~out_ready;
            b++;
        end
        check_val(tag, got_q.size(), n);
    endtask

    task automatic wait_reads(input int n, input int budget);
        int b = 0;
        while (rda_cnt + rdb_cnt < n && b < budget) begin @(posedge clk); #1; b++; end
    endtask

    task automatic word_chk(input string tag, input int j, input logic [34:0] e);
        check_val(tag, (j < got_q.size()) ? {29'b0, got_q[j]} : 64'hdead, {29'b0, e});
    endtask

    initial begin
        do_reset();
        // Reset values
        @(negedge clk);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_outs", {out_data, out_pair, out_first, out_last}, 0);
        check_val("rst_rd", {fifo_rd1, fifo_rd2, fifo_rd3, fifo_rd4}, 0);
        check_val("rst_bc", burst_count, 0);

        // L=0 keeps IDLE
        @(posedge clk); #1;
        load(4); packer_len = 13'd0; enable = 1'b1;
        cycles(5);
        check_val("len0_reads", rda_cnt + rdb_cnt, 0);

        // L=4, full rate, alternating bursts
        do_reset();
        load(16); packer_len = 13'd4; out_ready = 1'b1; enable = 1'b1;
        wait_words("l4_count", 16, 60, 1'b0);
        enable = 1'b0;
        for (int j = 0; j < 16; j++)
            word_chk("l4_word", j, exp_w(((j / 4) % 2) == 1, (j / 8) * 4 + j % 4,
                                         (j % 4) == 0, (j % 4) == 3));
        check_val("l4_nogap", (stamp_q.size() >= 16) ? stamp_q[15] - stamp_q[0] : 0, 15);

        // L=2, out_ready toggling: order preserved, occupancy capped at 3
        do_reset();
        load(16); packer_len = 13'd2; out_ready = 1'b1; enable = 1'b1;
        wait_words("l2_count", 12, 80, 1'b1);
        enable = 1'b0;
        for (int j = 0; j < 12; j++)
            word_chk("l2_word", j, exp_w(((j / 2) % 2) == 1, (j / 4) * 2 + j % 2,
                                         (j % 2) == 0, (j % 2) == 1));
        check_val("l2_max_out", max_out, 3);

        // L=3, FIFO4 empty after the A burst: pair B waits
        do_reset();
        hold = 4'b1000; load(3); packer_len = 13'd3; out_ready = 1'b1; enable = 1'b1;
        cycles(20);
        check_val("l3_a_words", got_q.size(), 3);
        check_val("l3_no_rdb", rdb_cnt, 0);
        hold = 4'b0; refresh_empty();
        wait_words("l3_count", 6, 30, 1'b0);
        for (int j = 3; j < 6; j++)
            word_chk("l3_word", j, exp_w(1'b1, j - 3, j == 3, j == 5));
        enable = 1'b0;

        // L=8, enable dropped after the 5th read, then re-enabled
        do_reset();
        load(16); packer_len = 13'd8; out_ready = 1'b1; enable = 1'b1;
        wait_reads(5, 40);
        enable = 1'b0;
        cycles(10);
        check_val("drop_reads", rda_cnt + rdb_cnt, 5);
        check_val("drop_words", got_q.size(), 5);
        word_chk("drop_w0", 0, exp_w(1'b0, 0, 1'b1, 1'b0));
        word_chk("drop_w4", 4, exp_w(1'b0, 4, 1'b0, 1'b0));
        enable = 1'b1;
        wait_words("reen_count", 6, 20, 1'b0);
        word_chk("reen_w5", 5, exp_w(1'b0, 5, 1'b1, 1'b0));
        enable = 1'b0;

        // Reset one cycle after the 3rd strobe with 2 words buffered
        do_reset();
        load(16); packer_len = 13'd4; out_ready = 1'b0; enable = 1'b1;
        wait_reads(3, 40);
        reset = 1'b1; enable = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_outs", {out_data, out_pair, out_first, out_last}, 0);
        check_val("mid_rst_rd", {fifo_rd1, fifo_rd3}, 0);
        out_ready = 1'b1;
        cycles(6);
        check_val("mid_rst_drop", got_q.size(), 0);

        // L=1, five bursts
        do_reset();
        load(8); packer_len = 13'd1; out_ready = 1'b1; enable = 1'b1;
        wait_reads(5, 40);
        enable = 1'b0;
        wait_words("l1_count", 5, 20, 1'b0);
        cycles(3);
        word_chk("l1_w3", 3, exp_w(1'b1, 1, 1'b1, 1'b1));
        word_chk("l1_w4", 4, exp_w(1'b0, 2, 1'b1, 1'b1));
`ifdef BURST_COUNT_EN
        check_val("burst_count", burst_count, 5);
`else
        check_val("burst_count", burst_count, 0);
`endif

        check_val("rd_rules", rule_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
